// File: rtl/extmem_arbiter_if.sv
// Requester-side and external-memory-side signals of the burst arbiter.
// slave = arbiter view; master = requesters plus memory (driver view).
interface extmem_arbiter_if #(
  parameter int LEN_W = 16
);
  logic [1:0]       req;
  logic [1:0]       we;
  logic [31:0]      addr0;
  logic [31:0]      addr1;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [31:0]      wdata0;
  logic [31:0]      wdata1;
  logic [1:0]       grant;
  logic [1:0]       beat_ack;
  logic [31:0]      rdata;
  logic [1:0]       done;
  logic             request_extmem;
  logic             write_extmem;
  logic [31:0]      addr_extmem;
  logic [31:0]      w_data;
  logic             valid_extmem;
  logic [31:0]      data_extmem;

  modport slave (
    input  req, we, addr0, addr1, len0, len1, wdata0, wdata1,
    input  valid_extmem, data_extmem,
    output grant, beat_ack, rdata, done,
    output request_extmem, write_extmem, addr_extmem, w_data
  );

  modport master (
    output req, we, addr0, addr1, len0, len1, wdata0, wdata1,
    output valid_extmem, data_extmem,
    input  grant, beat_ack, rdata, done,
    input  request_extmem, write_extmem, addr_extmem, w_data
  );
endinterface

// File: rtl/extmem_arbiter.sv
// Round-robin arbiter running whole bursts from two requesters on one external memory port.
// Latency: grant 1 cycle after req is sampled in IDLE; one beat per cycle with valid_extmem high.
// Backpressure: valid_extmem low stalls the burst, holding address, count and request.
module extmem_arbiter #(
  parameter int ADDR_INC = 1,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  extmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             req_ext_q, req_ext_d;
  logic             wr_q, wr_d;

  logic             winner;
  logic [LEN_W-1:0] win_len;
  logic             beat;

  always_comb begin
    // On a tie the requester that was not served last wins.
    winner    = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    win_len   = winner ? bus.len1 : bus.len0;
    beat      = req_ext_q & bus.valid_extmem;

    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    req_ext_d = req_ext_q;
    wr_d      = wr_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          last_d  = winner;
          grant_d = winner ? 2'b10 : 2'b01;
          len_d   = win_len;
          addr_d  = winner ? bus.addr1 : bus.addr0;
          cnt_d   = '0;
          if (win_len == '0) begin
            state_d = DONE;
          end else begin
            state_d   = BURST;
            req_ext_d = 1'b1;
            wr_d      = bus.we[winner];
          end
        end
      end
      BURST: begin
        if (beat) begin
          cnt_d  = cnt_q + LEN_W'(1);
          addr_d = addr_q + 32'(ADDR_INC);
          // Request drops on the edge that completes the final beat.
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d   = DONE;
            req_ext_d = 1'b0;
            wr_d      = 1'b0;
          end
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      req_ext_q <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      req_ext_q <= req_ext_d;
      wr_q      <= wr_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.done           = (state_q == DONE) ? grant_q : 2'b00;
  assign bus.request_extmem = req_ext_q;
  assign bus.write_extmem   = wr_q;
  assign bus.addr_extmem    = addr_q;
  assign bus.beat_ack       = {2{beat}} & grant_q;
  assign bus.rdata          = bus.data_extmem;
  assign bus.w_data         = grant_q[1] ? bus.wdata1 :
                              grant_q[0] ? bus.wdata0 : 32'h0;

endmodule
